uart_io_sequencer: RTL and testbench

- Memory-mapped controller between the multi-cycle RISC-V core's I/O port and the UART Tx/Rx engine.
- Buffers outgoing bytes in a TX FIFO and sequences each byte into the UART with a start/busy handshake.
- Captures received bytes into an RX FIFO and exposes status and control registers to the core.
- Replaces direct core-driven register selection; the core never waits on the UART.

---
 rtl/uart_io_pkg.sv | 35 +++
 rtl/uart_io_fifo.sv | 79 +++++++
 rtl/uart_io_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_uart_io_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_io_pkg.sv
// Shared constants for the UART I/O sequencer: register addresses,
// STATUS/CTRL bit positions and the TX sequencer state encoding.
// Optional feature macro used by this slice: UART_IO_IRQ_EN.
package uart_io_pkg;

    localparam logic [1:0] ADDR_TXDATA = 2'd0;
    localparam logic [1:0] ADDR_RXDATA = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int ST_TX_FULL      = 0;
    localparam int ST_TX_EMPTY     = 1;
    localparam int ST_RX_FULL      = 2;
    localparam int ST_RX_EMPTY     = 3;
    localparam int ST_TX_OVF       = 4;
    localparam int ST_RX_OVF       = 5;
    localparam int ST_RX_UNF       = 6;
    localparam int ST_TX_TIMEOUT   = 7;
    localparam int ST_TX_LEVEL_LSB = 8;
    localparam int ST_RX_LEVEL_LSB = 16;

    localparam int CTRL_TX_EN      = 0;
    localparam int CTRL_CLR_STICKY = 1;
    localparam int CTRL_FLUSH      = 2;
    localparam int CTRL_RX_IRQ_EN  = 3;
    localparam int CTRL_ERR_IRQ_EN = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_io_fifo.sv
// Synchronous FIFO used for both the TX and RX byte queues.
// A pop on an empty FIFO is ignored; a push into a full FIFO is accepted
// only when a pop happens in the same cycle. Flush overrides push and pop.
module uart_io_fifo
    import uart_io_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW:0]      level_r;
    logic             pop_s;
    logic             push_s;

    assign full  = (level_r == LVL_FULL);
    assign empty = (level_r == {(AW+1){1'b0}});
    assign level = level_r;
    assign head  = mem_r[rd_ptr_r];

    // Effective push/pop after full/empty qualification
    always_comb begin
        pop_s  = pop & ~empty;
        push_s = push & (~full | pop_s);
    end

    // Pointer and level bookkeeping; flush returns the FIFO to empty
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            level_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (push_s && !pop_s) begin
                level_r <= level_r + LVL_ONE;
            end else if (pop_s && !push_s) begin
                level_r <= level_r - LVL_ONE;
            end else begin
                level_r <= level_r;
            end
        end
    end

    // Storage array, cleared on reset so the head never carries stale data
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s && !flush) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/uart_io_sequencer.sv
// Memory-mapped bridge between the core I/O port and the UART engine.
// TX bytes are queued and sequenced into the UART with a start/busy
// handshake guarded by a busy-rise timeout; RX bytes are queued for the
// core. Optional interrupt output enabled by macro UART_IO_IRQ_EN.
module uart_io_sequencer
    import uart_io_pkg::*;
#(
    parameter int TX_DEPTH     = 8,
    parameter int RX_DEPTH     = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_wr_en,
    input  logic        cpu_rd_en,
    input  logic [1:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_start,
    input  logic        uart_tx_busy,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid
`ifdef UART_IO_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TW  = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    tx_state_e     state_r;
    logic [TW-1:0] tmo_cnt_r;
    logic          tx_en_r;
    logic          tx_ovf_r;
    logic          rx_ovf_r;
    logic          rx_unf_r;
    logic          tx_timeout_r;

    logic          wr_s;
    logic          rd_s;
    logic          flush_s;
    logic          clr_sticky_s;
    logic          tx_push_s;
    logic          tx_pop_s;
    logic          rx_pop_s;
    logic          tmo_hit_s;
    logic          tx_ovf_set_s;
    logic          rx_ovf_set_s;
    logic          rx_unf_set_s;
    logic [31:0]   status_s;
    logic [31:0]   ctrl_rd_s;
    logic          unused_wdata_s;

    logic [7:0]    tx_head_s;
    logic          tx_full_s;
    logic          tx_empty_s;
    logic [TAW:0]  tx_level_s;
    logic [7:0]    rx_head_s;
    logic          rx_full_s;
    logic          rx_empty_s;
    logic [RAW:0]  rx_level_s;

    assign unused_wdata_s = ^cpu_wdata[31:3];

    // Bus decode: a write wins over a simultaneous read, which is then suppressed
    always_comb begin
        wr_s         = cpu_wr_en;
        rd_s         = cpu_rd_en & ~cpu_wr_en;
        flush_s      = wr_s & (cpu_addr == ADDR_CTRL) & cpu_wdata[CTRL_FLUSH];
        clr_sticky_s = wr_s & (cpu_addr == ADDR_CTRL) & cpu_wdata[CTRL_CLR_STICKY];
        tx_push_s    = wr_s & (cpu_addr == ADDR_TXDATA);
        rx_pop_s     = rd_s & (cpu_addr == ADDR_RXDATA) & ~rx_empty_s;
        tx_pop_s     = (state_r == IDLE) & tx_en_r & ~tx_empty_s & ~uart_tx_busy & ~flush_s;
        tmo_hit_s    = (state_r == WAIT_HI) & ~uart_tx_busy & (tmo_cnt_r == TMO_LAST);
        tx_ovf_set_s = tx_push_s & tx_full_s & ~tx_pop_s & ~flush_s;
        rx_ovf_set_s = uart_rx_valid & rx_full_s & ~rx_pop_s & ~flush_s;
        rx_unf_set_s = rd_s & (cpu_addr == ADDR_RXDATA) & rx_empty_s;
    end

    uart_io_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush_s),
        .push  (tx_push_s),
        .pop   (tx_pop_s),
        .wdata (cpu_wdata[7:0]),
        .head  (tx_head_s),
        .full  (tx_full_s),
        .empty (tx_empty_s),
        .level (tx_level_s)
    );

    uart_io_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush_s),
        .push  (uart_rx_valid),
        .pop   (rx_pop_s),
        .wdata (uart_rx_data),
        .head  (rx_head_s),
        .full  (rx_full_s),
        .empty (rx_empty_s),
        .level (rx_level_s)
    );

`ifdef UART_IO_IRQ_EN
    logic rx_irq_en_r;
    logic err_irq_en_r;

    // CTRL storage including the interrupt enables
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_en_r      <= 1'b1;
            rx_irq_en_r  <= 1'b0;
            err_irq_en_r <= 1'b0;
        end else if (wr_s && (cpu_addr == ADDR_CTRL)) begin
            tx_en_r      <= cpu_wdata[CTRL_TX_EN];
            rx_irq_en_r  <= cpu_wdata[CTRL_RX_IRQ_EN];
            err_irq_en_r <= cpu_wdata[CTRL_ERR_IRQ_EN];
        end else begin
            tx_en_r      <= tx_en_r;
        end
    end

    // Registered interrupt: RX data pending or any sticky error, per enable
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= (rx_irq_en_r & ~rx_empty_s)
                 | (err_irq_en_r & (tx_ovf_r | rx_ovf_r | rx_unf_r | tx_timeout_r));
        end
    end

    // CTRL readback of the stored bits
    always_comb begin
        ctrl_rd_s                  = 32'h0000_0000;
        ctrl_rd_s[CTRL_TX_EN]      = tx_en_r;
        ctrl_rd_s[CTRL_RX_IRQ_EN]  = rx_irq_en_r;
        ctrl_rd_s[CTRL_ERR_IRQ_EN] = err_irq_en_r;
    end
`else
    // CTRL storage: only tx_en is kept in this build
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_en_r <= 1'b1;
        end else if (wr_s && (cpu_addr == ADDR_CTRL)) begin
            tx_en_r <= cpu_wdata[CTRL_TX_EN];
        end else begin
            tx_en_r <= tx_en_r;
        end
    end

    // CTRL readback of the stored bits
    always_comb begin
        ctrl_rd_s             = 32'h0000_0000;
        ctrl_rd_s[CTRL_TX_EN] = tx_en_r;
    end
`endif

    // Sticky error flags: a new event in the same cycle as a clear is kept
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ovf_r     <= 1'b0;
            rx_ovf_r     <= 1'b0;
            rx_unf_r     <= 1'b0;
            tx_timeout_r <= 1'b0;
        end else begin
            tx_ovf_r     <= tx_ovf_set_s | (tx_ovf_r & ~clr_sticky_s);
            rx_ovf_r     <= rx_ovf_set_s | (rx_ovf_r & ~clr_sticky_s);
            rx_unf_r     <= rx_unf_set_s | (rx_unf_r & ~clr_sticky_s);
            tx_timeout_r <= tmo_hit_s    | (tx_timeout_r & ~clr_sticky_s);
        end
    end

    // STATUS word assembly
    always_comb begin
        status_s                = 32'h0000_0000;
        status_s[ST_TX_FULL]    = tx_full_s;
        status_s[ST_TX_EMPTY]   = tx_empty_s;
        status_s[ST_RX_FULL]    = rx_full_s;
        status_s[ST_RX_EMPTY]   = rx_empty_s;
        status_s[ST_TX_OVF]     = tx_ovf_r;
        status_s[ST_RX_OVF]     = rx_ovf_r;
        status_s[ST_RX_UNF]     = rx_unf_r;
        status_s[ST_TX_TIMEOUT] = tx_timeout_r;
        status_s[ST_TX_LEVEL_LSB +: 8] = 8'(tx_level_s);
        status_s[ST_RX_LEVEL_LSB +: 8] = 8'(rx_level_s);
    end

    // Registered read data; holds its value when no read is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata <= 32'h0000_0000;
        end else if (rd_s) begin
            case (cpu_addr)
                ADDR_RXDATA: cpu_rdata <= rx_empty_s ? 32'h0000_0000 : {24'h00_0000, rx_head_s};
                ADDR_STATUS: cpu_rdata <= status_s;
                ADDR_CTRL:   cpu_rdata <= ctrl_rd_s;
                default:     cpu_rdata <= 32'h0000_0000;
            endcase
        end else begin
            cpu_rdata <= cpu_rdata;
        end
    end

    // TX sequencer: pop a byte, pulse start once, wait for busy to rise then fall
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            tmo_cnt_r     <= {TW{1'b0}};
            uart_tx_data  <= 8'h00;
            uart_tx_start <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (tx_pop_s) begin
                        uart_tx_data  <= tx_head_s;
                        uart_tx_start <= 1'b1;
                        state_r       <= START;
                    end else begin
                        uart_tx_start <= 1'b0;
                    end
                end
                START: begin
                    uart_tx_start <= 1'b0;
                    tmo_cnt_r     <= {TW{1'b0}};
                    state_r       <= WAIT_HI;
                end
                WAIT_HI: begin
                    uart_tx_start <= 1'b0;
                    if (uart_tx_busy) begin
                        state_r <= WAIT_LO;
                    end else if (tmo_hit_s) begin
                        state_r <= IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
                    end
                end
                WAIT_LO: begin
                    uart_tx_start <= 1'b0;
                    if (!uart_tx_busy) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    uart_tx_start <= 1'b0;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_io_sequencer.sv
// Self-checking bench for uart_io_sequencer (default build, no irq port).
module tb_uart_io_sequencer;
    import uart_io_pkg::*;

    logic        clk;
    logic        reset;
    logic        cpu_wr_en;
    logic        cpu_rd_en;
    logic [1:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_start;
    logic        uart_tx_busy;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;

    int total = 0;
    int bad   = 0;

    // UART transmitter model state
    int         cyc        = 0;
    bit         uart_resp  = 1'b1;
    int         busy_hold  = 4;
    int         busy_cnt   = 0;
    int         start_count = 0;
    int         last_start = -100;
    logic [7:0] sent_q[$];

    // Reference model state for the randomized phase
    logic [7:0] tq[$];
    logic [7:0] rq[$];
    bit         m_tovf, m_rovf, m_unf, m_tmo;
    logic [31:0] m_last;

    uart_io_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_wr_en     (cpu_wr_en),
        .cpu_rd_en     (cpu_rd_en),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_start (uart_tx_start),
        .uart_tx_busy  (uart_tx_busy),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", name, got, exp);
        end
    endtask

    // UART model: records each start, raises busy for busy_hold cycles
    initial begin
        uart_tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (uart_tx_start === 1'b1) begin
                check("start_spacing_ge3", 32'(cyc - last_start >= 3), 32'd1);
                sent_q.push_back(uart_tx_data);
                start_count++;
                last_start = cyc;
                if (uart_resp) busy_cnt = busy_hold;
            end
            uart_tx_busy = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cpu_wr(input logic [1:0] a, input logic [31:0] d);
        cpu_wr_en = 1'b1; cpu_addr = a; cpu_wdata = d;
        tick();
        cpu_wr_en = 1'b0;
    endtask

    task automatic cpu_rd(input logic [1:0] a, output logic [31:0] d);
        cpu_rd_en = 1'b1; cpu_addr = a;
        tick();
        cpu_rd_en = 1'b0;
        d = cpu_rdata;
    endtask

    task automatic wait_starts(input int n, input int budget, input string name);
        int b;
        b = budget;
        while (start_count < n && b > 0) begin
            tick();
            b--;
        end
        check(name, 32'(start_count), 32'(n));
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'h0;
        s[0] = (tq.size() == 8);
        s[1] = (tq.size() == 0);
        s[2] = (rq.size() == 8);
        s[3] = (rq.size() == 0);
        s[4] = m_tovf;
        s[5] = m_rovf;
        s[6] = m_unf;
        s[7] = m_tmo;
        s[15:8]  = 8'(tq.size());
        s[23:16] = 8'(rq.size());
        return s;
    endfunction

    // op: 0 none, 1 write, 2 read, 3 write+read
    typedef struct {
        int          op;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        rxv;
        logic [7:0]  rxd;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[20];

    initial begin
        logic [31:0] d;
        int base;
        int qb;
        int s1;

        reset = 1'b1; cpu_wr_en = 1'b0; cpu_rd_en = 1'b0; cpu_addr = 2'd0;
        cpu_wdata = 32'h0; uart_rx_data = 8'h00; uart_rx_valid = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_tx_data", 32'(uart_tx_data), 32'h0);
        check("rst_tx_start", 32'(uart_tx_start), 32'h0);
        reset = 1'b0;
        tick();
        cpu_rd(ADDR_STATUS, d); check("rst_status", d, 32'h0000_000A);
        cpu_rd(ADDR_CTRL, d);   check("rst_ctrl", d, 32'h0000_0001);

        // ---------------- register table ----------------
        vt[0]  = '{1, ADDR_CTRL,   32'h0,  1'b0, 8'h00, 32'h0};
        vt[1]  = '{2, ADDR_CTRL,   32'h0,  1'b0, 8'h00, 32'h0000_0000};
        vt[2]  = '{2, ADDR_STATUS, 32'h0,  1'b0, 8'h00, 32'h0000_000A};
        vt[3]  = '{0, ADDR_TXDATA, 32'h0,  1'b1, 8'h5A, 32'h0};
        vt[4]  = '{2, ADDR_STATUS, 32'h0,  1'b0, 8'h00, 32'h0001_0002};
        vt[5]  = '{2, ADDR_RXDATA, 32'h0,  1'b0, 8'h00, 32'h0000_005A};
        vt[6]  = '{2, ADDR_RXDATA, 32'h0,  1'b0, 8'h00, 32'h0000_0000};
        vt[7]  = '{2, ADDR_STATUS, 32'h0,  1'b0, 8'h00, 32'h0000_004A};
        vt[8]  = '{1, ADDR_CTRL,   32'h2,  1'b0, 8'h00, 32'h0};
        vt[9]  = '{2, ADDR_STATUS, 32'h0,  1'b0, 8'h00, 32'h0000_000A};
        vt[10] = '{3, ADDR_CTRL,   32'h0,  1'b0, 8'h00, 32'h0000_000A};
        vt[11] = '{1, ADDR_TXDATA, 32'h11, 1'b0, 8'h00, 32'h0};
        vt[12] = '{2, ADDR_STATUS, 32'h0,  1'b0, 8'h00, 32'h0000_0108};
        vt[13] = '{1, ADDR_CTRL,   32'h4,  1'b1, 8'h33, 32'h0};
        vt[14] = '{2, ADDR_STATUS, 32'h0,  1'b0, 8'h00, 32'h0000_000A};
        vt[15] = '{2, ADDR_TXDATA, 32'h0,  1'b0, 8'h00, 32'h0000_0000};
        vt[16] = '{2, ADDR_CTRL,   32'h0,  1'b0, 8'h00, 32'h0000_0000};
        vt[17] = '{1, ADDR_CTRL,   32'h1B, 1'b0, 8'h00, 32'h0};
        vt[18] = '{2, ADDR_CTRL,   32'h0,  1'b0, 8'h00, 32'h0000_0001};
        vt[19] = '{1, ADDR_CTRL,   32'h0,  1'b0, 8'h00, 32'h0};
        for (int i = 0; i < 20; i++) begin
            cpu_wr_en     = (vt[i].op == 1) || (vt[i].op == 3);
            cpu_rd_en     = (vt[i].op == 2) || (vt[i].op == 3);
            cpu_addr      = vt[i].addr;
            cpu_wdata     = vt[i].wdata;
            uart_rx_valid = vt[i].rxv;
            uart_rx_data  = vt[i].rxd;
            tick();
            cpu_wr_en = 1'b0; cpu_rd_en = 1'b0; uart_rx_valid = 1'b0;
            if (vt[i].op >= 2) check($sformatf("vec%0d", i), cpu_rdata, vt[i].exp);
        end

        // ---------------- two bytes out ----------------
        base = start_count; qb = sent_q.size();
        cpu_wr(ADDR_CTRL, 32'h1);
        cpu_wr(ADDR_TXDATA, 32'h41);
        cpu_wr(ADDR_TXDATA, 32'h42);
        wait_starts(base + 2, 80, "t1_starts");
        check("t1_byte0", 32'(sent_q[qb]), 32'h41);
        check("t1_byte1", 32'(sent_q[qb+1]), 32'h42);
        repeat (10) tick();
        cpu_rd(ADDR_STATUS, d);
        check("t1_tx_empty", 32'(d[1]), 32'd1);

        // ---------------- overflow with tx disabled ----------------
        cpu_wr(ADDR_CTRL, 32'h0);
        base = start_count; qb = sent_q.size();
        for (int i = 0; i < 9; i++) cpu_wr(ADDR_TXDATA, 32'h60 + 32'(i));
        cpu_rd(ADDR_STATUS, d);
        check("t2_tx_full", 32'(d[0]), 32'd1);
        check("t2_tx_ovf", 32'(d[4]), 32'd1);
        check("t2_tx_level", 32'(d[15:8]), 32'd8);
        check("t2_no_start", 32'(start_count), 32'(base));
        cpu_wr(ADDR_CTRL, 32'h1);
        wait_starts(base + 8, 200, "t2_starts");
        repeat (20) tick();
        check("t2_exactly8", 32'(start_count), 32'(base + 8));
        for (int i = 0; i < 8; i++)
            check($sformatf("t2_byte%0d", i), 32'(sent_q[qb+i]), 32'h60 + 32'(i));
        cpu_wr(ADDR_CTRL, 32'h3);

        // ---------------- busy timeout ----------------
        uart_resp = 1'b0;
        base = start_count; qb = sent_q.size();
        cpu_wr(ADDR_TXDATA, 32'h71);
        cpu_wr(ADDR_TXDATA, 32'h72);
        wait_starts(base + 1, 20, "t3_first_start");
        s1 = last_start;
        wait_starts(base + 2, 60, "t3_second_start");
        check("t3_gap_17_19", 32'((last_start - s1 >= 17) && (last_start - s1 <= 19)), 32'd1);
        check("t3_byte1", 32'(sent_q[qb+1]), 32'h72);
        cpu_rd(ADDR_STATUS, d);
        check("t3_timeout_flag", 32'(d[7]), 32'd1);
        repeat (30) tick();
        uart_resp = 1'b1;
        cpu_wr(ADDR_CTRL, 32'h3);
        cpu_rd(ADDR_STATUS, d);
        check("t3_cleared", d, 32'h0000_000A);

        // ---------------- RX full with simultaneous push/pop ----------------
        cpu_wr(ADDR_CTRL, 32'h0);
        for (int i = 0; i < 8; i++) begin
            uart_rx_valid = 1'b1; uart_rx_data = 8'h80 + 8'(i);
            tick();
            uart_rx_valid = 1'b0;
        end
        cpu_rd(ADDR_STATUS, d); check("t4_full", d, 32'h0008_0006);
        uart_rx_valid = 1'b1; uart_rx_data = 8'h99;
        cpu_rd(ADDR_RXDATA, d);
        uart_rx_valid = 1'b0;
        check("t4_oldest", d, 32'h0000_0080);
        cpu_rd(ADDR_STATUS, d); check("t4_still_full_no_ovf", d, 32'h0008_0006);
        for (int i = 1; i < 8; i++) begin
            cpu_rd(ADDR_RXDATA, d);
            check($sformatf("t4_rd%0d", i), d, 32'h80 + 32'(i));
        end
        cpu_rd(ADDR_RXDATA, d); check("t4_last", d, 32'h0000_0099);
        cpu_rd(ADDR_STATUS, d); check("t4_empty", d, 32'h0000_000A);

        // ---------------- reset during WAIT_LO ----------------
        busy_hold = 20;
        for (int i = 0; i < 4; i++) cpu_wr(ADDR_TXDATA, 32'hA1 + 32'(i));
        base = start_count;
        cpu_wr(ADDR_CTRL, 32'h1);
        wait_starts(base + 1, 20, "t5_start");
        repeat (3) tick();
        cpu_rd(ADDR_CTRL, d); check("t5_pre_ctrl", d, 32'h1);
        reset = 1'b1;
        tick();
        check("t5_rdata", cpu_rdata, 32'h0);
        check("t5_tx_data", 32'(uart_tx_data), 32'h0);
        check("t5_tx_start", 32'(uart_tx_start), 32'h0);
        reset = 1'b0;
        base = start_count;
        cpu_rd(ADDR_STATUS, d); check("t5_status", d, 32'h0000_000A);
        cpu_rd(ADDR_CTRL, d);   check("t5_ctrl", d, 32'h0000_0001);
        repeat (40) tick();
        check("t5_no_start", 32'(start_count), 32'(base));
        busy_hold = 4;

        // ---------------- randomized register traffic vs model ----------------
        cpu_wr(ADDR_CTRL, 32'h6);
        tq.delete(); rq.delete();
        m_tovf = 1'b0; m_rovf = 1'b0; m_unf = 1'b0; m_tmo = 1'b0;
        cpu_rd(ADDR_CTRL, d); check("rand_init_ctrl", d, 32'h0);
        m_last = 32'h0;
        base = start_count;
        for (int it = 0; it < 400; it++) begin
            int          op;
            logic [1:0]  a;
            logic [31:0] wd;
            logic [31:0] st;
            logic [7:0]  rxd;
            logic [7:0]  hb;
            bit          rxv, wr, rd, fl, cl, s_t, s_r, s_u;
            op  = $urandom_range(0, 3);
            a   = 2'($urandom_range(0, 3));
            wd  = $urandom;
            if (a == ADDR_CTRL) begin
                wd[0] = 1'b0;
                if ($urandom_range(0, 7) != 0) wd[2] = 1'b0;
            end
            rxv = ($urandom_range(0, 2) == 0);
            rxd = 8'($urandom);
            wr  = (op == 1) || (op == 3);
            rd  = (op == 2);
            fl  = wr && (a == ADDR_CTRL) && wd[2];
            cl  = wr && (a == ADDR_CTRL) && wd[1];
            st  = m_status();
            s_t = 1'b0; s_r = 1'b0; s_u = 1'b0;
            if (rd) begin
                case (a)
                    ADDR_RXDATA: begin
                        if (rq.size() == 0) begin
                            m_last = 32'h0; s_u = 1'b1;
                        end else begin
                            hb = rq.pop_front();
                            m_last = {24'h0, hb};
                        end
                    end
                    ADDR_STATUS: m_last = st;
                    ADDR_CTRL:   m_last = 32'h0;
                    default:     m_last = 32'h0;
                endcase
            end
            if (wr && (a == ADDR_TXDATA)) begin
                if (tq.size() < 8) tq.push_back(wd[7:0]);
                else s_t = 1'b1;
            end
            if (rxv && !fl) begin
                if (rq.size() < 8) rq.push_back(rxd);
                else s_r = 1'b1;
            end
            if (cl) begin
                m_tovf = 1'b0; m_rovf = 1'b0; m_unf = 1'b0; m_tmo = 1'b0;
            end
            m_tovf |= s_t; m_rovf |= s_r; m_unf |= s_u;
            if (fl) begin
                tq.delete(); rq.delete();
            end
            cpu_wr_en = wr; cpu_rd_en = (op >= 2); cpu_addr = a; cpu_wdata = wd;
            uart_rx_valid = rxv; uart_rx_data = rxd;
            tick();
            cpu_wr_en = 1'b0; cpu_rd_en = 1'b0; uart_rx_valid = 1'b0;
            if (op >= 2) check($sformatf("rand%0d", it), cpu_rdata, m_last);
        end
        check("rand_no_start", 32'(start_count), 32'(base));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
